// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM arbiter (data types, owner states, rr pointer encoding)
package ram_arb_pkg;
  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;
  localparam logic [1:0] DT_ILL  = 2'b11;
  localparam logic PTR_IF = 1'b0;
  localparam logic PTR_D  = 1'b1;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: two-input arbiter producing a one-hot grant for the fetch and load/store requesters.
//   in:  req_if, req_d  requests; ptr_q favoured requester on contention (RAM_ARB_RR_EN only)
//   out: gnt_if, gnt_d  one-hot grant; ptr_d next pointer value
//   RAM_ARB_RR_EN defined: alternate on contention; otherwise fixed D > IF.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic req_if,
  input  logic req_d,
  input  logic ptr_q,
  output logic gnt_if,
  output logic gnt_d,
  output logic ptr_d
);
`ifdef RAM_ARB_RR_EN
  always_comb begin
    gnt_d  = req_d & (~req_if | ptr_q == PTR_D);
    gnt_if = req_if & ~gnt_d;
    // only a contested grant moves the pointer, and it moves to the loser
    ptr_d  = (req_if & req_d) ? (gnt_d ? PTR_IF : PTR_D) : ptr_q;
  end
`else
  always_comb begin
    gnt_d  = req_d;
    gnt_if = req_if & ~req_d;
    ptr_d  = ptr_q;
  end
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between instruction fetch and load/store with a registered read response.
//   clk, rst (async, active-high)
//   fetch:      if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   load/store: d_req, d_we, d_type, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata, d_err
//   RAM side:   ram_write_EN, ram_read_EN, ram_data_type, ram_address, ram_write_data <- ram_read_data
//   Macro RAM_ARB_RR_EN (in ram_arb_pick) selects round-robin instead of fixed D > IF priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_type,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              ram_write_EN,
  output logic              ram_read_EN,
  output logic [1:0]        ram_data_type,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data
);
  logic   ptr_q, ptr_d;
  logic   err_q, err_d;
  logic   d_ill, d_rd, d_wr;
  owner_e owner_q, owner_d;

  ram_arb_pick u_pick (
    .req_if (if_req),
    .req_d  (d_req),
    .ptr_q  (ptr_q),
    .gnt_if (if_gnt),
    .gnt_d  (d_gnt),
    .ptr_d  (ptr_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      ptr_q   <= PTR_IF;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // an illegal-type grant is accepted but touches nothing in the RAM
  always_comb begin
    d_ill   = d_type == DT_ILL;
    d_rd    = d_gnt & ~d_we & ~d_ill;
    d_wr    = d_gnt & d_we & ~d_ill;
    owner_d = if_gnt ? OWN_IF : d_rd ? OWN_D : OWN_NONE;
    err_d   = d_gnt & d_ill;
  end

  always_comb begin
    ram_write_EN   = d_wr;
    ram_read_EN    = if_gnt | d_rd;
    ram_data_type  = d_gnt ? d_type : DT_WORD;
    ram_address    = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    ram_write_data = d_gnt ? d_wdata : '0;
  end

  assign if_rvalid = owner_q == OWN_IF;
  assign d_rvalid  = owner_q == OWN_D;
  assign if_rdata  = if_rvalid ? ram_read_data : '0;
  assign d_rdata   = d_rvalid ? ram_read_data : '0;
  assign d_err     = err_q;
endmodule
